// File: rtl/ula_pkg.sv
// Shared opcodes, FSM state and debug view for the multi-cycle ALU.
package ula_pkg;

    localparam int OP_AND  = 0;
    localparam int OP_OR   = 1;
    localparam int OP_ADD  = 2;
    localparam int OP_SUB  = 3;
    localparam int OP_SLT  = 4;
    localparam int OP_SLTS = 5;
    localparam int OP_XOR  = 6;
    localparam int OP_NOR  = 7;
    localparam int OP_SLL  = 8;
    localparam int OP_SRL  = 9;
    localparam int OP_SRA  = 10;
    localparam int OP_MUL  = 11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DONE
    } state_t;

    typedef struct packed {
        state_t state;
        logic   mul_busy;
    } ula_dbg_t;

endpackage

// File: rtl/ula_multiciclo_if.sv
// Operand/result bus of the multi-cycle ALU; the producer side is the master.
interface ula_multiciclo_if #(
    parameter int WIDTH = 8,
    parameter int OP_W  = 4
);
    // Handshake: an op transfers on any rising edge with in_valid && in_ready,
    // a result on any rising edge with out_valid && out_ready. A result with
    // out_valid high and out_ready low stays bit-stable until it transfers.
    logic [WIDTH-1:0] entrada1;
    logic [WIDTH-1:0] entrada2;
    logic [OP_W-1:0]  sinal_ula;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] saida_ula;
    logic             zero;
    logic             carry;
    logic             overflow;
    logic             negative;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output entrada1, entrada2, sinal_ula, in_valid, out_ready,
        input  in_ready, saida_ula, zero, carry, overflow, negative, out_valid
    );

    modport slave (
        input  entrada1, entrada2, sinal_ula, in_valid, out_ready,
        output in_ready, saida_ula, zero, carry, overflow, negative, out_valid
    );

endinterface

// File: rtl/ula_mult_serial.sv
// Unsigned serial shift-add multiplier: one partial product on start, then one per cycle.
module ula_mult_serial #(
    parameter int WIDTH = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;

    // Bit 0 is folded in at start, so bits 1..WIDTH-1 take WIDTH-1 more steps.
    assign done    = busy && (cnt == CW'(WIDTH - 1));
    assign product = acc;

    always_ff @(posedge clock) begin
        if (reset) begin
            busy   <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            cnt    <= '0;
            acc    <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
            mcand  <= {{(WIDTH-1){1'b0}}, a, 1'b0};
            mplier <= b >> 1;
        end else if (busy) begin
            if (done) begin
                busy <= 1'b0;
            end else begin
                acc    <= acc + (mplier[0] ? mcand : '0);
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ula_multiciclo.sv
// Handshaked ALU: single-cycle logic/arith/compare/shift ops plus a serial
// unsigned multiply; result and flags are held until the consumer takes them.
module ula_multiciclo
    import ula_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int OP_W  = 4
) (
    input  logic              clock,
    input  logic              reset,
    ula_multiciclo_if.slave   bus,
    output ula_dbg_t          dbg
);
    localparam logic [WIDTH-1:0] SH_LIM = WIDTH'(WIDTH);

    state_t state, state_nxt;

    logic [WIDTH-1:0]   a, b;
    logic               is_mul, accept, mul_start, mul_busy, mul_done;
    logic [2*WIDTH-1:0] mul_product;

    logic [WIDTH-1:0]        alu_res, sub_res;
    logic [WIDTH:0]          add_full;
    logic signed [WIDTH-1:0] sra_res;
    logic                    alu_c, alu_v;

    logic [WIDTH-1:0] ld_res;
    logic             ld_c, ld_v, load_en;

    logic [WIDTH-1:0] res_q;
    logic             zero_q, carry_q, overflow_q, negative_q;

    assign a         = bus.entrada1;
    assign b         = bus.entrada2;
    assign is_mul    = (bus.sinal_ula == OP_W'(OP_MUL));
    assign accept    = bus.in_valid && bus.in_ready;
    assign mul_start = accept && is_mul;

    // in_ready depends only on state and out_ready, never on in_valid.
    assign bus.in_ready  = (state == S_IDLE) || ((state == S_DONE) && bus.out_ready);
    assign bus.out_valid = (state == S_DONE);
    assign bus.saida_ula = res_q;
    assign bus.zero      = zero_q;
    assign bus.carry     = carry_q;
    assign bus.overflow  = overflow_q;
    assign bus.negative  = negative_q;

    assign dbg.state    = state;
    assign dbg.mul_busy = mul_busy;

    ula_mult_serial #(.WIDTH(WIDTH)) u_mult (
        .clock   (clock),
        .reset   (reset),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    always_comb begin
        alu_res  = '0;
        alu_c    = 1'b0;
        alu_v    = 1'b0;
        add_full = {1'b0, a} + {1'b0, b};
        sub_res  = a - b;
        sra_res  = $signed(a) >>> b;
        case (bus.sinal_ula)
            OP_W'(OP_AND):  alu_res = a & b;
            OP_W'(OP_OR):   alu_res = a | b;
            OP_W'(OP_ADD): begin
                alu_res = add_full[WIDTH-1:0];
                alu_c   = add_full[WIDTH];
                alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (add_full[WIDTH-1] != a[WIDTH-1]);
            end
            OP_W'(OP_SUB): begin
                alu_res = sub_res;
                alu_c   = (a < b);
                alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_W'(OP_SLT):  alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_W'(OP_SLTS): alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_W'(OP_XOR):  alu_res = a ^ b;
            OP_W'(OP_NOR):  alu_res = ~(a | b);
            OP_W'(OP_SLL):  alu_res = (b >= SH_LIM) ? '0 : (a << b);
            OP_W'(OP_SRL):  alu_res = (b >= SH_LIM) ? '0 : (a >> b);
            OP_W'(OP_SRA):  alu_res = (b >= SH_LIM) ? {WIDTH{a[WIDTH-1]}} : sra_res;
            default:        alu_res = '0;
        endcase
    end

    // The output register loads either a freshly accepted single-cycle op or
    // the finished product; both never coincide since in_ready is low in MUL.
    always_comb begin
        load_en = (accept && !is_mul) || ((state == S_MUL) && mul_done);
        if (state == S_MUL) begin
            ld_res = mul_product[WIDTH-1:0];
            ld_c   = 1'b0;
            ld_v   = |mul_product[2*WIDTH-1:WIDTH];
        end else begin
            ld_res = alu_res;
            ld_c   = alu_c;
            ld_v   = alu_v;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) state_nxt = is_mul ? S_MUL : S_DONE;
            S_MUL:  if (mul_done) state_nxt = S_DONE;
            S_DONE: begin
                if (bus.out_ready) begin
                    if (bus.in_valid) state_nxt = is_mul ? S_MUL : S_DONE;
                    else              state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            res_q      <= '0;
            zero_q     <= 1'b0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
            negative_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (load_en) begin
                res_q      <= ld_res;
                zero_q     <= (ld_res == '0);
                carry_q    <= ld_c;
                overflow_q <= ld_v;
                negative_q <= ld_res[WIDTH-1];
            end
        end
    end

endmodule

// File: tb/tb_ula_multiciclo.sv
// Bench for ula_multiciclo: directed vector table, handshake corner sequences
// and a randomized stream, all checked through an expected-result queue.
module tb_ula_multiciclo;
    import ula_pkg::*;

    localparam int W = 8;
    localparam int E = W + 4;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] op;
        logic [7:0] res;
        logic       z, c, v, n;
    } vec_t;

    logic     clock;
    logic     reset;
    ula_dbg_t dbg;

    ula_multiciclo_if #(.WIDTH(W), .OP_W(4)) bus ();

    ula_multiciclo #(.WIDTH(W), .OP_W(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus),
        .dbg   (dbg)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    int           n_cmp = 0;
    int           n_bad = 0;
    int           n_pop = 0;
    logic [E-1:0] exp_q[$];
    logic [E-1:0] drv_exp;
    logic         last_ov, last_ir;
    vec_t         vecs[18];

    function automatic logic [E-1:0] ref_model(input logic [7:0] a, input logic [7:0] b,
                                               input logic [3:0] op);
        logic [7:0]  r;
        logic        c, v;
        logic [8:0]  s;
        logic [15:0] p;
        r = 8'h00; c = 1'b0; v = 1'b0;
        case (op)
            4'h0: r = a & b;
            4'h1: r = a | b;
            4'h2: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[7:0]; c = s[8];
                v = (a[7] == b[7]) && (r[7] != a[7]);
            end
            4'h3: begin
                r = a - b; c = (a < b);
                v = (a[7] != b[7]) && (r[7] != a[7]);
            end
            4'h4: r = (a < b) ? 8'h01 : 8'h00;
            4'h5: r = ($signed(a) < $signed(b)) ? 8'h01 : 8'h00;
            4'h6: r = a ^ b;
            4'h7: r = ~(a | b);
            4'h8: r = (b >= 8) ? 8'h00 : (a << b);
            4'h9: r = (b >= 8) ? 8'h00 : (a >> b);
            4'hA: begin
                r = a;
                for (int i = 0; i < 8; i++) if (i < b) r = {a[7], r[7:1]};
            end
            4'hB: begin
                p = {8'h00, a} * {8'h00, b};
                r = p[7:0]; v = |p[15:8];
            end
            default: r = 8'h00;
        endcase
        return {r, (r == 8'h00), c, v, r[7]};
    endfunction

    // scoreboard
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // One cycle: observe at the falling edge, then step past the rising edge.
    task automatic tick();
        @(negedge clock);
        last_ov = bus.out_valid;
        last_ir = bus.in_ready;
        if (!reset) begin
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 32'(bus.out_valid), 32'd0);
                end else begin
                    check("result_flags",
                          32'({bus.saida_ula, bus.zero, bus.carry, bus.overflow, bus.negative}),
                          32'(exp_q[0]));
                    if (bus.out_ready) begin
                        void'(exp_q.pop_front());
                        n_pop++;
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) exp_q.push_back(drv_exp);
        end
        @(posedge clock);
        #1;
    endtask

    // driver tasks
    task automatic drive_op(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                            input logic [E-1:0] e);
        bus.entrada1  = a;
        bus.entrada2  = b;
        bus.sinal_ula = op;
        bus.in_valid  = 1'b1;
        drv_exp       = e;
    endtask

    task automatic run_vec(input vec_t t, input int idx);
        int lat, ir_low;
        bit seen;
        bus.out_ready = 1'b1;
        drive_op(t.a, t.b, t.op, {t.res, t.z, t.c, t.v, t.n});
        tick();
        check($sformatf("vec%0d_accept", idx), 32'(last_ir), 32'd1);
        bus.in_valid  = 1'b0;
        bus.entrada1  = 8'($urandom);
        bus.entrada2  = 8'($urandom);
        bus.sinal_ula = 4'($urandom);
        lat = 0; ir_low = 0; seen = 1'b0;
        while (!seen && lat < 20) begin
            tick();
            lat++;
            if (!last_ir) ir_low++;
            if (last_ov) seen = 1'b1;
        end
        check($sformatf("vec%0d_latency", idx), 32'(lat), (t.op == 4'hB) ? 32'd9 : 32'd1);
        check($sformatf("vec%0d_in_ready_low", idx), 32'(ir_low), (t.op == 4'hB) ? 32'd8 : 32'd0);
        check($sformatf("vec%0d_drained", idx), 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pops0, ov_seen, guard;
        logic [7:0] ra, rb;
        logic [3:0] rop;

        vecs[0]  = '{8'hFF, 8'h01, 4'h2, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{8'h80, 8'h01, 4'h3, 8'h7F, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{8'h80, 8'h01, 4'h5, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{8'h80, 8'h01, 4'h4, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{8'h10, 8'h11, 4'hB, 8'h10, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{8'h0F, 8'h03, 4'hB, 8'h2D, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{8'h80, 8'h03, 4'hA, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{8'h80, 8'h09, 4'h9, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{8'h5A, 8'hC3, 4'hF, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{8'hF0, 8'h3C, 4'h0, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{8'hF0, 8'h0F, 4'h1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{8'hAA, 8'hFF, 4'h6, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{8'h00, 8'h00, 4'h7, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[13] = '{8'h01, 8'h07, 4'h8, 8'h80, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[14] = '{8'h01, 8'h02, 4'h3, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[15] = '{8'h7F, 8'h01, 4'h2, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[16] = '{8'h80, 8'hC8, 4'hA, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[17] = '{8'h03, 8'h08, 4'h8, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};

        reset         = 1'b1;
        bus.entrada1  = '0;
        bus.entrada2  = '0;
        bus.sinal_ula = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        drv_exp       = '0;
        repeat (3) tick();

        check("reset_outputs",
              32'({bus.saida_ula, bus.zero, bus.carry, bus.overflow, bus.negative, bus.out_valid}),
              32'd0);
        check("reset_state", 32'(dbg.state), 32'(S_IDLE));
        reset = 1'b0;
        tick();
        check("reset_in_ready", 32'(last_ir), 32'd1);

        for (int i = 0; i < 18; i++) run_vec(vecs[i], i);

        // Backpressure: held result, then a same-cycle accept/retire stream.
        bus.out_ready = 1'b0;
        drive_op(8'h10, 8'h20, 4'h2, ref_model(8'h10, 8'h20, 4'h2));
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_out_valid", 32'(last_ov), 32'd1);
            check("bp_in_ready", 32'(last_ir), 32'd0);
        end
        pops0 = n_pop;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            drive_op(ra, rb, 4'h2, ref_model(ra, rb, 4'h2));
            tick();
            check("stream_out_valid", 32'(last_ov), 32'd1);
            check("stream_in_ready", 32'(last_ir), 32'd1);
        end
        bus.in_valid = 1'b0;
        tick();
        check("stream_last_valid", 32'(last_ov), 32'd1);
        check("stream_pops", 32'(n_pop - pops0), 32'd5);
        tick();
        check("stream_idle", 32'(last_ov), 32'd0);

        // Reset in the middle of a multiply discards it.
        drive_op(8'h10, 8'h11, 4'hB, ref_model(8'h10, 8'h11, 4'hB));
        tick();
        bus.in_valid = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        exp_q.delete();
        tick();
        reset = 1'b0;
        check("mulrst_outputs",
              32'({bus.saida_ula, bus.zero, bus.carry, bus.overflow, bus.negative, bus.out_valid}),
              32'd0);
        check("mulrst_in_ready", 32'(bus.in_ready), 32'd1);
        check("mulrst_busy", 32'(dbg.mul_busy), 32'd0);
        ov_seen = 0;
        repeat (12) begin
            tick();
            if (last_ov) ov_seen++;
        end
        check("mulrst_no_stale", 32'(ov_seen), 32'd0);

        // Randomized stream with random backpressure.
        for (int i = 0; i < 300; i++) begin
            ra  = 8'($urandom);
            rb  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 10)) : 8'($urandom);
            rop = 4'($urandom_range(0, 15));
            drive_op(ra, rb, rop, ref_model(ra, rb, rop));
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        guard = 0;
        while (exp_q.size() > 0 && guard < 40) begin
            tick();
            guard++;
        end
        check("random_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ula_multiciclo.md
# ula_multiciclo

Parametrised, handshaked successor to the datapath's 8-bit ALU. It registers operand/opcode pairs on a valid/ready handshake and executes logic, add/sub, compare and shift ops in one cycle, plus unsigned multiply as a WIDTH-cycle serial shift-add. It holds the result and a full flag set (zero, carry, overflow, negative) until the consumer accepts it. It sits between the register-file read stage and writeback and supports back-to-back single-cycle ops.

## Interface
- WIDTH, 8, operand/result width (≥4)
- OP_W, 4, opcode width
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- entrada1  in  WIDTH  operand A
- entrada2  in  WIDTH  operand B (shift amount for shifts)
- sinal_ula  in  OP_W  opcode
- in_valid  in  1  operands/opcode valid
- in_ready  out  1  block can accept an op this cycle
- saida_ula  out  WIDTH  registered result
- zero / carry / overflow / negative  out  1 each  registered flags
- out_valid  out  1  result and flags valid
- out_ready  in  1  consumer accepts result

## Operation
- Opcodes: 0000 and, 0001 or, 0010 add, 0011 sub, 0100 slt (unsigned, result 1/0), 0101 slts (signed), 0110 xor, 0111 nor, 1000 sll, 1001 srl, 1010 sra, 1011 mul (unsigned, low WIDTH bits). All others: result 0.
- Shifts: amount is the full entrada2 value; amount ≥ WIDTH gives 0 for sll/srl and all sign bits for sra.
- zero = (saida_ula == 0), for every opcode including undefined ones.
- negative = saida_ula[WIDTH-1].
- carry:
  - add: carry out of bit WIDTH-1.
  - sub: borrow (entrada1 < entrada2, unsigned).
  - all other ops: 0.
- overflow:
  - add/sub: two's-complement signed overflow.
  - mul: 1 when the upper WIDTH bits of the 2·WIDTH product are nonzero.
  - all other ops: 0.
- Operands and opcode are captured at the accept edge (in_valid && in_ready). Later changes on the inputs do not affect the op in flight.
- FSM states:
  - IDLE: in_ready = 1. On accept of a non-mul op, go to DONE. On accept of mul, go to MUL with counter = 0.
  - MUL: in_ready = 0. One shift-add step per cycle. When counter reaches WIDTH-1, go to DONE.
  - DONE: out_valid = 1 and result is held.
    - out_ready = 0: stay in DONE; in_ready = 0.
    - out_ready = 1 and in_valid = 1: the new op is accepted in the same cycle (in_ready = 1). A non-mul op stays in DONE with the new result; a mul goes to MUL.
    - out_ready = 1 and in_valid = 0: go to IDLE.
- Reset, at any time including mid-MUL: state goes to IDLE, the op in flight is discarded with no result produced, and the counter is cleared.

## Timing
- Reset values: saida_ula = 0, zero = 0, carry = 0, overflow = 0, negative = 0, out_valid = 0. in_ready = 1 from the first cycle after reset.
- Non-mul latency: out_valid is high at the edge after accept (1 cycle).
- Mul latency: out_valid is high WIDTH+1 edges after accept (9 for WIDTH = 8).
- Throughput: one non-mul op per cycle while out_ready = 1.
- in_ready is combinational from state and out_ready. No other combinational input-to-output paths.
- While out_valid && !out_ready, saida_ula and all flags are bit-stable.

## Structure
- Shared package ula_pkg:
  - opcode localparams (OP_AND … OP_MUL)
  - FSM state enum (S_IDLE, S_MUL, S_DONE)
- Sub-module ula_mult_serial (parameter WIDTH):
  - start/busy/done interface
  - accumulator, shifted multiplicand and counter
  - 2·WIDTH product output
- The top level holds the single-cycle datapath, flag logic, FSM and output registers.

## Test plan
- Add 0xFF + 0x01 → saida_ula 0x00, zero = 1, carry = 1, overflow = 0, negative = 0; out_valid one cycle after accept.
- Sub 0x80 − 0x01 → 0x7F, overflow = 1, carry = 0. Then slts 0x80 vs 0x01 → 0x01, and slt 0x80 vs 0x01 → 0x00.
- Mul 0x10 × 0x11 → 0x10, overflow = 1; in_ready = 0 for 8 cycles; out_valid 9 edges after accept. Also 0x0F × 0x03 → 0x2D, overflow = 0.
- Sra 0x80 by 3 → 0xF0, negative = 1. Srl 0x80 by 9 → 0x00, zero = 1. Opcode 1111 → 0x00, zero = 1.
- Backpressure: hold out_ready = 0 for 3 cycles → result and flags unchanged, in_ready = 0. Then release with in_valid high and stream 4 adds → 4 results on 4 consecutive edges.
- Assert reset on cycle 4 of a mul → next cycle out_valid = 0, in_ready = 1, all outputs 0; no stale result ever appears.
